// File: rtl/img_filter_pkg.sv
// Shared types and helpers for the image filter window controller.
package img_filter_pkg;

   localparam int unsigned PIXEL_W_DEF = 8;
   typedef logic [PIXEL_W_DEF-1:0] pixel_t;

   localparam int unsigned BORDER_ZERO = 0;
   localparam int unsigned BORDER_REPL = 1;

   typedef enum logic {IDLE, RD_ROW} state_t;

   // Bit offset of window element (row r, column j) in the flattened window bus.
   function automatic int unsigned win_offset(input int unsigned r, input int unsigned j,
                                              input int unsigned kernel, input int unsigned pixel_w);
      return (r * kernel + j) * pixel_w;
   endfunction

endpackage

// File: rtl/window_line_buffer.sv
// One image line of pixels; returns KERNEL consecutive pixels from a column with right-edge fill.
module window_line_buffer
   import img_filter_pkg::*;
#(
   parameter int unsigned PIXEL_W     = 8,
   parameter int unsigned IMG_WIDTH   = 512,
   parameter int unsigned KERNEL      = 3,
   parameter int unsigned BORDER_MODE = BORDER_ZERO,
   parameter int unsigned ADDR_W      = $clog2(IMG_WIDTH)
) (
   input  logic                      i_clk,
   input  logic                      i_wr_en,
   input  logic [ADDR_W-1:0]         i_wr_addr,
   input  logic [PIXEL_W-1:0]        i_wr_data,
   input  logic [ADDR_W-1:0]         i_rd_col,
   output logic [KERNEL*PIXEL_W-1:0] o_rd_data
);

   localparam logic [ADDR_W-1:0] LAST_COL = ADDR_W'(IMG_WIDTH - 1);

   logic [PIXEL_W-1:0] mem [IMG_WIDTH];
   logic [31:0]        col;

   always_ff @(posedge i_clk) begin
      if (i_wr_en) begin
         mem[i_wr_addr] <= i_wr_data;
      end
   end

   always_comb begin
      o_rd_data = '0;
      col       = '0;
      for (int unsigned j = 0; j < KERNEL; j++) begin
         col = 32'(i_rd_col) + j;
         if (col < IMG_WIDTH) begin
            o_rd_data[j*PIXEL_W +: PIXEL_W] = mem[col[ADDR_W-1:0]];
         end else if (BORDER_MODE == BORDER_REPL) begin
            o_rd_data[j*PIXEL_W +: PIXEL_W] = mem[LAST_COL];
         end
      end
   end

endmodule

// File: rtl/window_ctrl_param.sv
// Streams raster pixels into a ring of KERNEL+1 line buffers and emits one KERNEL x KERNEL
// window per output column with valid/ready on both sides and a per-row interrupt.
module window_ctrl_param
   import img_filter_pkg::*;
#(
   parameter int unsigned PIXEL_W     = 8,
   parameter int unsigned IMG_WIDTH   = 512,
   parameter int unsigned KERNEL      = 3,
   parameter int unsigned BORDER_MODE = BORDER_ZERO
) (
   input  logic                              i_clk,
   input  logic                              i_rst,
   input  logic [PIXEL_W-1:0]                i_pixel_data,
   input  logic                              i_pixel_valid,
   output logic                              o_pixel_ready,
   output logic [KERNEL*KERNEL*PIXEL_W-1:0]  o_window_data,
   output logic                              o_window_valid,
   input  logic                              i_window_ready,
   output logic                              o_intr
);

   localparam int unsigned NUM_BUF = KERNEL + 1;
   localparam int unsigned BW      = $clog2(NUM_BUF);
   localparam int unsigned CW      = $clog2(IMG_WIDTH);
   localparam int unsigned FW      = $clog2(NUM_BUF * IMG_WIDTH + 1);

   localparam logic [FW-1:0] FILL_CAP   = FW'(NUM_BUF * IMG_WIDTH);
   localparam logic [FW-1:0] FILL_START = FW'(KERNEL * IMG_WIDTH);
   localparam logic [FW-1:0] FILL_ROW   = FW'(IMG_WIDTH);
   localparam logic [CW-1:0] LAST_COL   = CW'(IMG_WIDTH - 1);
   localparam logic [BW-1:0] LAST_BUF   = BW'(NUM_BUF - 1);

   logic [BW-1:0] wr_buf, rd_buf;
   logic [CW-1:0] wr_col, rd_col;
   logic [FW-1:0] fill;
   state_t        state;
   logic          accept, win_fire, retire;

   logic [KERNEL*PIXEL_W-1:0] buf_rd [NUM_BUF];
   int unsigned               sel_sum;
   logic [BW-1:0]             sel;

   // Capping fill at NUM_BUF lines keeps the writer out of the KERNEL buffers being read.
   assign o_pixel_ready = ~i_rst & (fill < FILL_CAP);
   assign accept        = i_pixel_valid & o_pixel_ready;
   assign win_fire      = o_window_valid & i_window_ready;
   assign retire        = win_fire & (rd_col == LAST_COL);

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         wr_buf <= '0;
         wr_col <= '0;
         fill   <= '0;
      end else begin
         if (accept) begin
            if (wr_col == LAST_COL) begin
               wr_col <= '0;
               wr_buf <= (wr_buf == LAST_BUF) ? '0 : wr_buf + 1'b1;
            end else begin
               wr_col <= wr_col + 1'b1;
            end
         end
         case ({accept, retire})
            2'b10:   fill <= fill + 1'b1;
            2'b01:   fill <= fill - FILL_ROW;
            2'b11:   fill <= fill + 1'b1 - FILL_ROW;
            default: fill <= fill;
         endcase
      end
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state          <= IDLE;
         rd_col         <= '0;
         rd_buf         <= '0;
         o_window_valid <= 1'b0;
         o_intr         <= 1'b0;
      end else begin
         o_intr <= 1'b0;
         case (state)
            IDLE: begin
               if (fill >= FILL_START) begin
                  state          <= RD_ROW;
                  o_window_valid <= 1'b1;
               end
            end
            RD_ROW: begin
               if (win_fire) begin
                  if (rd_col == LAST_COL) begin
                     rd_col         <= '0;
                     rd_buf         <= (rd_buf == LAST_BUF) ? '0 : rd_buf + 1'b1;
                     state          <= IDLE;
                     o_window_valid <= 1'b0;
                     o_intr         <= 1'b1;
                  end else begin
                     rd_col <= rd_col + 1'b1;
                  end
               end
            end
            default: begin
               state          <= IDLE;
               o_window_valid <= 1'b0;
            end
         endcase
      end
   end

   for (genvar b = 0; b < NUM_BUF; b++) begin : g_buf
      window_line_buffer #(
         .PIXEL_W     (PIXEL_W),
         .IMG_WIDTH   (IMG_WIDTH),
         .KERNEL      (KERNEL),
         .BORDER_MODE (BORDER_MODE)
      ) u_buf (
         .i_clk     (i_clk),
         .i_wr_en   (accept && (wr_buf == BW'(b))),
         .i_wr_addr (wr_col),
         .i_wr_data (i_pixel_data),
         .i_rd_col  (rd_col),
         .o_rd_data (buf_rd[b])
      );
   end

   // Window row r comes from ring slot rd_buf + r, wrapped without a divider.
   always_comb begin
      o_window_data = '0;
      sel_sum       = 0;
      sel           = '0;
      for (int unsigned r = 0; r < KERNEL; r++) begin
         sel_sum = 32'(rd_buf) + r;
         if (sel_sum >= NUM_BUF) begin
            sel_sum = sel_sum - NUM_BUF;
         end
         sel = BW'(sel_sum);
         o_window_data[win_offset(r, 0, KERNEL, PIXEL_W) +: KERNEL*PIXEL_W] = buf_rd[sel];
      end
   end

endmodule
